// File: rtl/i2c_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// hardware_control_pkg
//
// Purpose: shared definitions for the hardware-control I2C sharing logic.
//   - arbStateT     : arbiter state encoding (IDLE / GRANT / GUARD)
//   - DEFAULT_*     : default guard and timeout lengths for the 2.5 MHz
//                     control clock
//   - cntWidth()    : width of a counter that must hold 0..maxValue
//   - idxWidth()    : width of an index into a vector of 'count' entries
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package hardware_control_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } arbStateT;

  // 8 cycles at 2.5 MHz is 3.2 us of guaranteed bus-free time
  localparam int DEFAULT_GUARD_CYCLES   = 8;
  // 2.5M cycles at 2.5 MHz is one second of continuous ownership
  localparam int DEFAULT_TIMEOUT_CYCLES = 2_500_000;

  // Never returns zero, so a parameter of 0 still gives a legal vector
  function automatic int cntWidth(input int maxValue);
    return (maxValue < 1) ? 1 : $clog2(maxValue + 1);
  endfunction

  function automatic int idxWidth(input int count);
    return (count < 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
//
// Purpose: combinational round-robin selector. Searches the eligible vector
// starting at pointer+1 and wrapping, returning the first hit.
//
// Ports:
//   eligible  in  NUM_CLIENTS  candidate clients
//   pointer   in  IDX_W        index of the most recently granted client
//   oneHot    out NUM_CLIENTS  one-hot selection (zero when nothing eligible)
//   index     out IDX_W        index of the selected client
//   valid     out 1            high when a client was selected
// ---------------------------------------------------------------------------
module rr_priority_pick
  import hardware_control_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int IDX_W       = idxWidth(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] eligible,
  input  logic [IDX_W-1:0]       pointer,
  output logic [NUM_CLIENTS-1:0] oneHot,
  output logic [IDX_W-1:0]       index,
  output logic                   valid
);

  // Walk NUM_CLIENTS positions after the pointer; the last position visited
  // is the pointer itself, so the previous owner has the lowest priority.
  always_comb begin
    int cand;
    oneHot = '0;
    index  = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int i = 1; i <= NUM_CLIENTS; i++) begin
      cand = (int'(pointer) + i) % NUM_CLIENTS;
      if (!valid && eligible[cand]) begin
        valid        = 1'b1;
        oneHot[cand] = 1'b1;
        index        = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
//
// Purpose: shares one physical I2C bus between NUM_CLIENTS masters. A
// round-robin arbiter hands out exclusive ownership, the owner's pull-low
// lines are merged onto the pads, and a guard gap keeps the bus idle
// between owners.
//
// Optional build macro: I2C_BUS_ARBITER_TIMEOUT_EN
//   defined   - grants longer than TIMEOUT_CYCLES are revoked, the owner is
//               flagged in opTimeout and locked out until it drops request
//   undefined - no revoke, opTimeout is constant zero
//
// Ports:
//   ipClk          in  1            system clock
//   ipReset        in  1            synchronous active-high reset
//   ipQuiet        in  1            blocks new grants (current owner kept)
//   ipRequest      in  NUM_CLIENTS  level bus requests
//   opGrant        out NUM_CLIENTS  registered one-hot-or-zero grant
//   ipClientSClk   in  NUM_CLIENTS  per-client SClk pull-low
//   ipClientData   in  NUM_CLIENTS  per-client Data pull-low
//   opI2C_SClk     out 1            merged SClk pull-low to pad
//   opI2C_Data     out 1            merged Data pull-low to pad
//   ipClearErrors  in  1            clears opTimeout
//   opTimeout      out NUM_CLIENTS  sticky timeout flags
// ---------------------------------------------------------------------------
module i2c_bus_arbiter
  import hardware_control_pkg::*;
#(
  parameter int NUM_CLIENTS    = 2,
  parameter int GUARD_CYCLES   = DEFAULT_GUARD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   ipClk,
  input  logic                   ipReset,
  input  logic                   ipQuiet,
  input  logic [NUM_CLIENTS-1:0] ipRequest,
  output logic [NUM_CLIENTS-1:0] opGrant,
  input  logic [NUM_CLIENTS-1:0] ipClientSClk,
  input  logic [NUM_CLIENTS-1:0] ipClientData,
  output logic                   opI2C_SClk,
  output logic                   opI2C_Data,
  input  logic                   ipClearErrors,
  output logic [NUM_CLIENTS-1:0] opTimeout
);

  localparam int IDX_W  = idxWidth(NUM_CLIENTS);
  localparam int GCNT_W = cntWidth(GUARD_CYCLES);

  arbStateT               state;
  arbStateT               stateNext;
  logic [NUM_CLIENTS-1:0] grantNext;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       ownerNext;
  logic [IDX_W-1:0]       pointer;
  logic [IDX_W-1:0]       pointerNext;
  logic [GCNT_W-1:0]      guardCnt;
  logic [GCNT_W-1:0]      guardCntNext;
  logic [NUM_CLIENTS-1:0] eligible;
  logic [NUM_CLIENTS-1:0] pickOneHot;
  logic [IDX_W-1:0]       pickIndex;
  logic                   pickValid;
  logic                   ownerReq;
  logic                   timeoutHit;

  assign ownerReq = ipRequest[owner];

  rr_priority_pick #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) picker (
    .eligible (eligible),
    .pointer  (pointer),
    .oneHot   (pickOneHot),
    .index    (pickIndex),
    .valid    (pickValid)
  );

`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
  localparam int TCNT_W = cntWidth(TIMEOUT_CYCLES);

  logic [TCNT_W-1:0]      grantCnt;
  logic [NUM_CLIENTS-1:0] lockout;
  logic [NUM_CLIENTS-1:0] timeoutFlags;
  logic [NUM_CLIENTS-1:0] timeoutSet;

  // A hit needs the request still high, so a drop on the same edge is an
  // ordinary release rather than a timeout.
  assign timeoutHit = (state == GRANT) && ownerReq &&
                      (grantCnt == TCNT_W'(TIMEOUT_CYCLES - 1));
  assign timeoutSet = timeoutHit ? opGrant : '0;
  assign eligible   = ipRequest & ~lockout;
  assign opTimeout  = timeoutFlags;

  // Grant-length counter restarts on every new grant. Lockout holds a
  // revoked client off until it lowers its request, and flags stay set
  // until cleared; a timeout on the clearing edge still sets its flag.
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      grantCnt     <= '0;
      lockout      <= '0;
      timeoutFlags <= '0;
    end else begin
      if ((state == GRANT) && (stateNext == GRANT))
        grantCnt <= grantCnt + TCNT_W'(1);
      else
        grantCnt <= '0;
      lockout      <= (lockout & ipRequest) | timeoutSet;
      timeoutFlags <= (ipClearErrors ? '0 : timeoutFlags) | timeoutSet;
    end
  end
`else
  logic unusedTimeout;

  assign timeoutHit    = 1'b0;
  assign eligible      = ipRequest;
  assign opTimeout     = '0;
  assign unusedTimeout = ipClearErrors ^ (TIMEOUT_CYCLES == 0);
`endif

  // Next-state logic: IDLE picks a winner, GRANT waits for the owner to
  // let go (or be revoked), GUARD counts out the bus-free gap.
  always_comb begin
    stateNext    = state;
    grantNext    = opGrant;
    ownerNext    = owner;
    pointerNext  = pointer;
    guardCntNext = guardCnt;
    case (state)
      IDLE: begin
        if (!ipQuiet && pickValid) begin
          grantNext   = pickOneHot;
          ownerNext   = pickIndex;
          pointerNext = pickIndex;
          stateNext   = GRANT;
        end
      end
      GRANT: begin
        if (!ownerReq || timeoutHit) begin
          grantNext    = '0;
          guardCntNext = '0;
          stateNext    = (GUARD_CYCLES == 0) ? IDLE : GUARD;
        end
      end
      GUARD: begin
        if (guardCnt == GCNT_W'(GUARD_CYCLES - 1))
          stateNext = IDLE;
        else
          guardCntNext = guardCnt + GCNT_W'(1);
      end
      default: begin
        stateNext = IDLE;
        grantNext = '0;
      end
    endcase
  end

  // State, grant and bus registers. The merge is masked by both the
  // current and next grant so the pads are released on the same edge the
  // grant drops, keeping the bus quiet throughout GUARD.
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state      <= IDLE;
      opGrant    <= '0;
      owner      <= '0;
      pointer    <= IDX_W'(NUM_CLIENTS - 1);
      guardCnt   <= '0;
      opI2C_SClk <= 1'b0;
      opI2C_Data <= 1'b0;
    end else begin
      state      <= stateNext;
      opGrant    <= grantNext;
      owner      <= ownerNext;
      pointer    <= pointerNext;
      guardCnt   <= guardCntNext;
      opI2C_SClk <= |(ipClientSClk & opGrant & grantNext);
      opI2C_Data <= |(ipClientData & opGrant & grantNext);
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_bus_arbiter
//
// Purpose: directed self-checking bench for i2c_bus_arbiter with four
// clients, an 8-cycle guard gap and a 20-cycle timeout. Inputs change 1 ns
// after each rising edge and outputs are sampled at the same point.
// Timeout checks follow I2C_BUS_ARBITER_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_i2c_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       quiet;
  logic [3:0] req;
  logic [3:0] sclkIn;
  logic [3:0] dataIn;
  logic       clr;
  logic [3:0] grant;
  logic       busSClk;
  logic       busData;
  logic [3:0] timeoutFlags;

  int compared   = 0;
  int mismatched = 0;

  logic [3:0] expGrant;
  int         order [5] = '{0, 1, 2, 3, 0};

  i2c_bus_arbiter #(
    .NUM_CLIENTS    (4),
    .GUARD_CYCLES   (8),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .ipClk         (clk),
    .ipReset       (reset),
    .ipQuiet       (quiet),
    .ipRequest     (req),
    .opGrant       (grant),
    .ipClientSClk  (sclkIn),
    .ipClientData  (dataIn),
    .opI2C_SClk    (busSClk),
    .opI2C_Data    (busData),
    .ipClearErrors (clr),
    .opTimeout     (timeoutFlags)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic q,
                               input logic [3:0] s, input logic [3:0] d,
                               input logic c);
    req    = r;
    quiet  = q;
    sclkIn = s;
    dataIn = d;
    clr    = c;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Runs the eight guard cycles after a release, all bus-silent
  task automatic guardGap(input string tag);
    for (int g = 0; g < 8; g++) begin
      tick();
      checkOutput(tag, 32'(grant), 32'(0));
      checkOutput({tag, "Bus"}, 32'({busSClk, busData}), 32'(0));
    end
  endtask

  // Directed sequence
  initial begin
    reset = 1'b1;
    applyStimulus(4'b1010, 1'b0, 4'b0000, 4'b0000, 1'b0);

    // Reset edge
    tick();
    $display("[TB] reset state");
    checkOutput("rstGrant", 32'(grant), 32'(0));
    checkOutput("rstSClk", 32'(busSClk), 32'(0));
    checkOutput("rstData", 32'(busData), 32'(0));
    checkOutput("rstTimeout", 32'(timeoutFlags), 32'(0));

    // First contest: pointer at 3, so client 1 beats client 3
    reset = 1'b0;
    tick();
    checkOutput("firstGrant", 32'(grant), 32'(4'b0010));
    req = 4'b1000;
    tick();
    checkOutput("firstRelease", 32'(grant), 32'(0));
    guardGap("firstGuard");
    tick();
    checkOutput("secondGrant", 32'(grant), 32'(4'b1000));

    // Return to idle before the round-robin run
    req = 4'b0000;
    tick();
    checkOutput("secondRelease", 32'(grant), 32'(0));
    guardGap("secondGuard");

    // Everyone requests; each owner releases after five owned cycles
    $display("[TB] round robin");
    applyStimulus(4'b1111, 1'b0, 4'b1111, 4'b1111, 1'b0);
    for (int r = 0; r < 5; r++) begin
      expGrant = 4'(1 << order[r]);
      tick();
      checkOutput("rrGrant", 32'(grant), 32'(expGrant));
      for (int h = 0; h < 4; h++) begin
        tick();
        checkOutput("rrHold", 32'(grant), 32'(expGrant));
        checkOutput("rrHoldBus", 32'({busSClk, busData}), 32'(2'b11));
      end
      req = 4'b1111 & ~expGrant;
      tick();
      checkOutput("rrRelease", 32'(grant), 32'(0));
      checkOutput("rrReleaseBus", 32'({busSClk, busData}), 32'(0));
      req = (r == 4) ? 4'b0000 : 4'b1111;
      guardGap("rrGuard");
    end

    // Bus merge: owner pulls SClk, a non-owner pulls Data
    $display("[TB] bus merge");
    applyStimulus(4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0);
    tick();
    checkOutput("mergeGrant", 32'(grant), 32'(4'b0001));
    sclkIn = 4'b0001;
    dataIn = 4'b0010;
    tick();
    checkOutput("mergeSClk", 32'(busSClk), 32'(1));
    checkOutput("mergeDataMasked", 32'(busData), 32'(0));
    applyStimulus(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
    tick();
    checkOutput("mergeRelease", 32'(grant), 32'(0));
    guardGap("mergeGuard");

    // Quiet blocks new grants only
    $display("[TB] quiet");
    applyStimulus(4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b0);
    for (int q = 0; q < 3; q++) begin
      tick();
      checkOutput("quietBlock", 32'(grant), 32'(0));
    end
    quiet = 1'b0;
    tick();
    checkOutput("quietFallGrant", 32'(grant), 32'(4'b0001));
    quiet = 1'b1;
    tick();
    checkOutput("quietKeepOwner", 32'(grant), 32'(4'b0001));
    tick();
    checkOutput("quietKeepOwner2", 32'(grant), 32'(4'b0001));
    req = 4'b0000;
    tick();
    checkOutput("quietRelease", 32'(grant), 32'(0));
    guardGap("quietGuard");
    req = 4'b0010;
    for (int q = 0; q < 3; q++) begin
      tick();
      checkOutput("quietIdleWait", 32'(grant), 32'(0));
    end
    quiet = 1'b0;
    tick();
    checkOutput("quietResume", 32'(grant), 32'(4'b0010));
    req = 4'b0000;
    tick();
    checkOutput("quietResumeRelease", 32'(grant), 32'(0));
    guardGap("quietResumeGuard");

    // Client 2 hangs onto the bus
    $display("[TB] long grant");
    req = 4'b0100;
    tick();
    checkOutput("longGrant", 32'(grant), 32'(4'b0100));
`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
    for (int t = 0; t < 19; t++) begin
      tick();
      checkOutput("toHold", 32'(grant), 32'(4'b0100));
    end
    tick();
    checkOutput("toRevoke", 32'(grant), 32'(0));
    checkOutput("toFlag", 32'(timeoutFlags), 32'(4'b0100));
    guardGap("toGuard");
    for (int t = 0; t < 3; t++) begin
      tick();
      checkOutput("toLockout", 32'(grant), 32'(0));
    end
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    checkOutput("toRegrant", 32'(grant), 32'(4'b0100));
    checkOutput("toFlagSticky", 32'(timeoutFlags), 32'(4'b0100));
    clr = 1'b1;
    tick();
    checkOutput("toClear", 32'(timeoutFlags), 32'(0));
    clr = 1'b0;
`else
    for (int t = 0; t < 25; t++) begin
      tick();
      checkOutput("noToHold", 32'(grant), 32'(4'b0100));
      checkOutput("noToFlag", 32'(timeoutFlags), 32'(0));
    end
    clr = 1'b1;
    tick();
    checkOutput("noToClear", 32'(timeoutFlags), 32'(0));
    clr = 1'b0;
`endif

    // Reset while client 2 is actively driving the bus
    $display("[TB] reset mid-grant");
    sclkIn = 4'b0100;
    dataIn = 4'b0100;
    tick();
    checkOutput("preRstBus", 32'({busSClk, busData}), 32'(2'b11));
    reset = 1'b1;
    tick();
    checkOutput("midRstGrant", 32'(grant), 32'(0));
    checkOutput("midRstSClk", 32'(busSClk), 32'(0));
    checkOutput("midRstData", 32'(busData), 32'(0));
    checkOutput("midRstTimeout", 32'(timeoutFlags), 32'(0));
    reset = 1'b0;
    applyStimulus(4'b1001, 1'b0, 4'b0000, 4'b0000, 1'b0);
    tick();
    checkOutput("postRstPointer", 32'(grant), 32'(4'b0001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
